mem_dump_seq: RTL and testbench
===============================

// Module: mem_dump_seq
// PURPOSE
//  Downstream consumer of the command-port receiver: on a "dump" command it walks memory from
//  start_adr to stop_adr inclusive, reads one byte per address over a req/ack port, and streams
//  each byte to the UART transmitter over a start/busy handshake. Reports done/err to host logic.
// PARAMETERS
//  ADDR_W      24   address width; matches receiver start/stop registers
//  RD_TIMEOUT  255  max cycles waiting for mem_ack before aborting with err (8-bit counter)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-low reset
//  cmd_strobe  in   1       one-cycle pulse (receiver pkt_done); registers valid the following cycle
//  start_adr   in   ADDR_W  first address to dump
//  stop_adr    in   ADDR_W  last address to dump (inclusive)
//  status      in   24      bit0 = dump request, bit1 = abort request; other bits ignored
//  mem_addr    out  ADDR_W  read address, stable while mem_rd high
//  mem_rd      out  1       read request, held high until mem_ack
//  mem_ack     in   1       one-cycle pulse, mem_data valid same cycle
//  mem_data    in   8       read data
//  tx_data     out  8       byte to transmit, stable from tx_start until tx_busy falls
//  tx_start    out  1       one-cycle pulse launching a UART byte
//  tx_busy     in   1       transmitter busy; rises the cycle after tx_start
//  busy        out  1       high from leaving IDLE until return to IDLE
//  done        out  1       one-cycle pulse: dump completed (normally or by abort)
//  err         out  1       one-cycle pulse: rejected command or read timeout
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state IDLE; mem_addr=0, mem_rd=0, tx_data=0, tx_start=0,
//    busy=0, done=0, err=0, abort_pend=0, timeout cnt=0. Reset mid-dump drops transfer at once.
//  - cmd_strobe registered (cmd_q); status/start_adr/stop_adr sampled in the cmd_q cycle.
//  - States: IDLE -> ARM -> REQ -> WAIT_ACK -> SEND -> WAIT_TX -> NEXT -> (REQ | FINISH) -> IDLE.
//  - IDLE: cmd_q & status[0]: if start_adr<=stop_adr -> ARM, latch addr=start_adr, last=stop_adr;
//    else err pulse, stay IDLE. cmd_q with status[0]=0 in IDLE: ignored.
//  - ARM: busy=1; -> REQ. REQ: mem_rd=1, mem_addr=addr, timeout cnt=0; -> WAIT_ACK.
//  - WAIT_ACK: mem_ack -> capture mem_data into tx_data, mem_rd=0, -> SEND. Else cnt++;
//    cnt==RD_TIMEOUT -> mem_rd=0, err pulse, busy=0, -> IDLE (no done).
//  - SEND: wait tx_busy==0, then tx_start=1 for one cycle -> WAIT_TX.
//  - WAIT_TX: tx_busy ignored in first cycle (guard); then tx_busy==0 -> NEXT.
//  - NEXT: addr==last or abort_pend -> FINISH; else addr=addr+1 -> REQ.
//    Compare precedes increment: stop_adr=all-ones terminates without wrapping to 0.
//  - FINISH: done pulse, busy=0, abort_pend=0 -> IDLE. Latency cmd_strobe->first mem_rd = 3 clk.
//  - Abort: cmd_q & status[1] while busy sets abort_pend; current byte completes, then FINISH.
//    status[0]&status[1] together in IDLE: dump starts and abort_pend set -> exactly one byte sent.
//  - Dump command (status[0]) while busy: ignored, no err.
//  - mem_ack outside WAIT_ACK ignored. start_adr==stop_adr: exactly one byte.
// CONFIGURATION
//  CHKSUM_EN defined: 8-bit sum (mod 256) of all data bytes sent; FINISH preceded by states
//   CSUM_SEND/CSUM_WAIT sending the sum byte with the same tx handshake; on abort the sum covers
//   bytes actually sent and is still transmitted; not sent on timeout. Sum cleared in ARM.
//  CHKSUM_EN undefined: no sum register, NEXT goes directly to FINISH.
// TESTING
//  1 reset=0 for 2 clk mid-dump -> all outputs 0 next cycle, state IDLE, later command accepted.
//  2 start=0x000010 stop=0x000013 status=1, mem_data=addr[7:0] -> tx bytes 10,11,12,13, done once;
//    with CHKSUM_EN fifth byte 0x46.
//  3 start=stop=0xFFFFFF -> exactly one mem_rd at 0xFFFFFF, one tx byte, done, no wrap to 0.
//  4 start=0x20 stop=0x1F -> err pulse 1 cycle after cmd_q, no mem_rd, busy stays 0.
//  5 mem_ack never returned -> err after RD_TIMEOUT cycles in WAIT_ACK, mem_rd low, no done.
//  6 dump 0x0..0xFF, abort strobe after 3rd tx_start -> 3 data bytes sent, done, busy low.

Source files
------------

// File: rtl/mem_dump_seq.sv
// Memory dump sequencer: walks start_adr..stop_adr, reads a byte per address, streams it to the UART.
// Optional feature macro: CHKSUM_EN appends a mod-256 sum byte after the data bytes.
module mem_dump_seq #(
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned RD_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_strobe,
   input  logic [ADDR_W-1:0] start_adr,
   input  logic [ADDR_W-1:0] stop_adr,
   input  logic [23:0]       status,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ARM,
      S_REQ,
      S_WAIT_ACK,
      S_SEND,
      S_WAIT_TX,
      S_NEXT,
`ifdef CHKSUM_EN
      S_CSUM_SEND,
      S_CSUM_WAIT,
`endif
      S_FINISH
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

   state_t              r_state, w_state;
   logic                r_cmd_q;
   logic [ADDR_W-1:0]   r_addr, w_addr;
   logic [ADDR_W-1:0]   r_last, w_last;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
   logic                r_mem_rd, w_mem_rd;
   logic [7:0]          r_tx_data, w_tx_data;
   logic                r_tx_start, w_tx_start;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
   logic                r_err, w_err;
   logic                r_abort_pend, w_abort_pend;
   logic [7:0]          r_cnt, w_cnt;
`ifdef CHKSUM_EN
   logic [7:0]          r_sum, w_sum;
`endif
   logic                w_dump;
   logic                w_abort;
   logic                w_unused_status;

   assign w_dump          = r_cmd_q & status[0];
   assign w_abort         = r_cmd_q & status[1];
   assign w_unused_status = ^status[23:2];

   always_comb begin
      w_state      = r_state;
      w_addr       = r_addr;
      w_last       = r_last;
      w_mem_addr   = r_mem_addr;
      w_mem_rd     = r_mem_rd;
      w_tx_data    = r_tx_data;
      w_tx_start   = 1'b0;
      w_busy       = r_busy;
      w_done       = 1'b0;
      w_err        = 1'b0;
      w_abort_pend = r_abort_pend;
      w_cnt        = r_cnt;
`ifdef CHKSUM_EN
      w_sum        = r_sum;
`endif
      // abort only latches while a dump is running; state cases below may override it
      if (w_abort && r_busy)
         w_abort_pend = 1'b1;

      case (r_state)
         S_IDLE: begin
            if (w_dump) begin
               if (start_adr <= stop_adr) begin
                  w_state      = S_ARM;
                  w_addr       = start_adr;
                  w_last       = stop_adr;
                  w_busy       = 1'b1;
                  w_abort_pend = status[1];
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         S_ARM: begin
`ifdef CHKSUM_EN
            w_sum   = '0;
`endif
            w_state = S_REQ;
         end
         S_REQ: begin
            w_mem_rd   = 1'b1;
            w_mem_addr = r_addr;
            w_cnt      = '0;
            w_state    = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (mem_ack) begin
               w_tx_data = mem_data;
               w_mem_rd  = 1'b0;
               w_state   = S_SEND;
            end else if (r_cnt == TO_LAST) begin
               w_mem_rd     = 1'b0;
               w_err        = 1'b1;
               w_busy       = 1'b0;
               w_abort_pend = 1'b0;
               w_state      = S_IDLE;
            end else begin
               w_cnt = r_cnt + 8'd1;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               w_tx_start = 1'b1;
`ifdef CHKSUM_EN
               w_sum      = r_sum + r_tx_data;
`endif
               w_state    = S_WAIT_TX;
            end
         end
         S_WAIT_TX: begin
            // r_tx_start marks the first cycle, before the transmitter can raise busy
            if (!r_tx_start && !tx_busy)
               w_state = S_NEXT;
         end
         S_NEXT: begin
            if (r_addr == r_last || r_abort_pend) begin
`ifdef CHKSUM_EN
               w_state = S_CSUM_SEND;
`else
               w_state = S_FINISH;
`endif
            end else begin
               w_addr  = r_addr + ADDR_W'(1);
               w_state = S_REQ;
            end
         end
`ifdef CHKSUM_EN
         S_CSUM_SEND: begin
            if (!tx_busy) begin
               w_tx_data  = r_sum;
               w_tx_start = 1'b1;
               w_state    = S_CSUM_WAIT;
            end
         end
         S_CSUM_WAIT: begin
            if (!r_tx_start && !tx_busy)
               w_state = S_FINISH;
         end
`endif
         S_FINISH: begin
            w_done       = 1'b1;
            w_busy       = 1'b0;
            w_abort_pend = 1'b0;
            w_state      = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cmd_q      <= 1'b0;
         r_addr       <= '0;
         r_last       <= '0;
         r_mem_addr   <= '0;
         r_mem_rd     <= 1'b0;
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_abort_pend <= 1'b0;
         r_cnt        <= '0;
`ifdef CHKSUM_EN
         r_sum        <= '0;
`endif
      end else begin
         r_state      <= w_state;
         r_cmd_q      <= cmd_strobe;
         r_addr       <= w_addr;
         r_last       <= w_last;
         r_mem_addr   <= w_mem_addr;
         r_mem_rd     <= w_mem_rd;
         r_tx_data    <= w_tx_data;
         r_tx_start   <= w_tx_start;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_err        <= w_err;
         r_abort_pend <= w_abort_pend;
         r_cnt        <= w_cnt;
`ifdef CHKSUM_EN
         r_sum        <= w_sum;
`endif
      end
   end

   assign mem_addr = r_mem_addr;
   assign mem_rd   = r_mem_rd;
   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_mem_dump_seq.sv
// Directed bench for mem_dump_seq: memory responder returns addr[7:0], UART model busy 3 cycles.
module tb_mem_dump_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_strobe;
   logic [23:0] start_adr;
   logic [23:0] stop_adr;
   logic [23:0] status;
   logic [23:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack  = 1'b0;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy  = 1'b0;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   mem_dump_seq #(.ADDR_W(24), .RD_TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .cmd_strobe(cmd_strobe),
      .start_adr(start_adr), .stop_adr(stop_adr), .status(status),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .busy(busy), .done(done), .err(err)
   );

`ifdef CHKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   int total = 0;
   int bad   = 0;

   logic [23:0] rd_q[$];
   logic [7:0]  tx_q[$];
   int          done_cnt = 0;
   int          err_cnt  = 0;
   int          viol_rd  = 0;
   int          viol_tx  = 0;
   logic        ack_en   = 1'b1;
   int          dly      = 0;
   int          tx_pend  = 0;
   int          tx_left  = 0;
   logic [7:0]  tx_hold  = 8'h00;
   logic        rd_prev  = 1'b0;
   logic [23:0] addr_hold = '0;

   // memory responder: ack on the third cycle of a request
   always @(negedge clk) begin
      if (mem_ack)
         mem_ack = 1'b0;
      else if (!mem_rd)
         dly = 0;
      else if (ack_en) begin
         if (dly == 2) begin
            mem_ack  = 1'b1;
            mem_data = mem_addr[7:0];
            dly      = 0;
         end else
            dly++;
      end
   end

   // UART model: busy rises the cycle after tx_start, held 3 cycles
   always @(negedge clk) begin
      if (tx_start && tx_busy) viol_tx++;
      if (busy && tx_busy && tx_data !== tx_hold) viol_tx++;
      if (tx_left > 0) begin
         tx_left--;
         if (tx_left == 0) tx_busy = 1'b0;
      end
      if (tx_pend != 0) begin
         tx_pend = 0;
         tx_busy = 1'b1;
         tx_left = 3;
      end
      if (tx_start) begin
         tx_q.push_back(tx_data);
         tx_hold = tx_data;
         tx_pend = 1;
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (mem_rd && !rd_prev) rd_q.push_back(mem_addr);
      if (mem_rd && rd_prev && mem_addr !== addr_hold) viol_rd++;
      addr_hold = mem_addr;
      rd_prev   = mem_rd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [23:0] st, input logic [23:0] s, input logic [23:0] e);
      @(negedge clk);
      status     = st;
      start_adr  = s;
      stop_adr   = e;
      cmd_strobe = 1'b1;
      @(negedge clk);
      cmd_strobe = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      int n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int rb, tb, d0, e0, n, hi;
      reset = 1'b0; cmd_strobe = 1'b0; start_adr = '0; stop_adr = '0; status = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst mem_addr", {8'd0, mem_addr}, 32'd0);
      chk("rst mem_rd",   {31'd0, mem_rd}, 32'd0);
      chk("rst tx_data",  {24'd0, tx_data}, 32'd0);
      chk("rst tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst busy",     {31'd0, busy}, 32'd0);
      chk("rst done",     {31'd0, done}, 32'd0);
      chk("rst err",      {31'd0, err}, 32'd0);
      reset = 1'b1;

      // reset in the middle of a long dump
      tb = tx_q.size();
      cmd(24'h1, 24'h000100, 24'h0001FF);
      n = 0;
      while (tx_q.size() < tb + 2 && n < 200) begin @(negedge clk); n++; end
      chk("t1 progress", {31'd0, tx_q.size() >= tb + 2}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("t1 busy",     {31'd0, busy}, 32'd0);
      chk("t1 mem_rd",   {31'd0, mem_rd}, 32'd0);
      chk("t1 tx_start", {31'd0, tx_start}, 32'd0);
      chk("t1 mem_addr", {8'd0, mem_addr}, 32'd0);
      chk("t1 tx_data",  {24'd0, tx_data}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rb = rd_q.size();
      repeat (10) @(negedge clk);
      chk("t1 idle busy", {31'd0, busy}, 32'd0);
      chk("t1 no rd",     rd_q.size() - rb, 32'd0);

      // normal dump 0x10..0x13
      rb = rd_q.size(); tb = tx_q.size(); d0 = done_cnt; e0 = err_cnt;
      cmd(24'h1, 24'h000010, 24'h000013);
      @(negedge clk); chk("t2 busy", {31'd0, busy}, 32'd1);
      @(negedge clk); chk("t2 rd early", {31'd0, mem_rd}, 32'd0);
      @(negedge clk); chk("t2 rd latency", {31'd0, mem_rd}, 32'd1);
      chk("t2 addr0", {8'd0, mem_addr}, 32'h10);
      wait_done("t2 done", 400);
      chk("t2 busy end", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("t2 ntx", tx_q.size() - tb, 4 + CS);
      for (int i = 0; i < 4; i++) chk("t2 byte", {24'd0, tx_q[tb + i]}, 32'h10 + i);
      if (CS != 0) chk("t2 csum", {24'd0, tx_q[tb + 4]}, 32'h46);
      chk("t2 nrd", rd_q.size() - rb, 32'd4);
      chk("t2 ndone", done_cnt - d0, 32'd1);
      chk("t2 nerr", err_cnt - e0, 32'd0);

      // single byte at the top of the address space
      rb = rd_q.size(); tb = tx_q.size(); d0 = done_cnt;
      cmd(24'h1, 24'hFFFFFF, 24'hFFFFFF);
      wait_done("t3 done", 200);
      repeat (3) @(negedge clk);
      chk("t3 nrd", rd_q.size() - rb, 32'd1);
      chk("t3 addr", {8'd0, rd_q[rb]}, 32'hFFFFFF);
      chk("t3 ntx", tx_q.size() - tb, 1 + CS);
      chk("t3 byte", {24'd0, tx_q[tb]}, 32'hFF);
      if (CS != 0) chk("t3 csum", {24'd0, tx_q[tb + 1]}, 32'hFF);
      chk("t3 ndone", done_cnt - d0, 32'd1);

      // inverted range rejected
      rb = rd_q.size(); d0 = done_cnt; e0 = err_cnt;
      cmd(24'h1, 24'h000020, 24'h00001F);
      @(negedge clk);
      chk("t4 err", {31'd0, err}, 32'd1);
      chk("t4 busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("t4 err pulse", {31'd0, err}, 32'd0);
      repeat (5) @(negedge clk);
      chk("t4 nrd", rd_q.size() - rb, 32'd0);
      chk("t4 nerr", err_cnt - e0, 32'd1);
      chk("t4 ndone", done_cnt - d0, 32'd0);

      // read timeout
      tb = tx_q.size(); d0 = done_cnt; e0 = err_cnt;
      ack_en = 1'b0;
      cmd(24'h1, 24'h000040, 24'h000050);
      n = 0;
      while (!mem_rd && n < 10) begin @(negedge clk); n++; end
      hi = mem_rd ? 1 : 0;
      n = 0;
      while (mem_rd && n < 400) begin
         @(negedge clk);
         if (mem_rd) hi++;
         n++;
      end
      chk("t5 rd cycles", hi, 32'd255);
      chk("t5 err", {31'd0, err}, 32'd1);
      chk("t5 busy", {31'd0, busy}, 32'd0);
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5 nerr", err_cnt - e0, 32'd1);
      chk("t5 ndone", done_cnt - d0, 32'd0);
      chk("t5 ntx", tx_q.size() - tb, 32'd0);

      // abort after the third byte
      rb = rd_q.size(); tb = tx_q.size(); d0 = done_cnt; e0 = err_cnt;
      cmd(24'h1, 24'h000000, 24'h0000FF);
      n = 0;
      while (tx_q.size() < tb + 3 && n < 300) begin @(negedge clk); n++; end
      chk("t6 three sent", {31'd0, tx_q.size() >= tb + 3}, 32'd1);
      cmd(24'h2, 24'h000000, 24'h0000FF);
      wait_done("t6 done", 300);
      chk("t6 busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("t6 ntx", tx_q.size() - tb, 3 + CS);
      for (int i = 0; i < 3; i++) chk("t6 byte", {24'd0, tx_q[tb + i]}, i);
      if (CS != 0) chk("t6 csum", {24'd0, tx_q[tb + 3]}, 32'h03);
      chk("t6 nrd", rd_q.size() - rb, 32'd3);
      chk("t6 ndone", done_cnt - d0, 32'd1);
      chk("t6 nerr", err_cnt - e0, 32'd0);

      chk("proto rd", viol_rd, 32'd0);
      chk("proto tx", viol_tx, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
